// File: rtl/updown_ctrl.sv
// Button conditioning, direction/run control and count-enable prescaler for the up/down counter.
// Optional single-step button is enabled by defining UPDOWN_CTRL_STEP_EN.

module updown_ctrl_btn #(
  parameter int DB_CYCLES = 4,
  parameter int DB_W      = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  logic            s1;
  logic            s2;
  logic            level;
  logic [DB_W-1:0] cnt;
  logic            update;

  // The level is accepted on the cycle the disagreement has lasted DB_CYCLES cycles.
  assign update = (s2 != level) && (cnt == DB_W'(DB_CYCLES - 1));
  assign press  = update && s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == level) begin
        cnt <= '0;
      end else if (update) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

module updown_ctrl #(
  parameter int DIV       = 5,
  parameter int DIV_W     = 26,
  parameter int DB_CYCLES = 4,
  parameter int DB_W      = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_dir,
  input  logic btn_run,
`ifdef UPDOWN_CTRL_STEP_EN
  input  logic btn_step,
`endif
  output logic tick,
  output logic flag,
  output logic running
);

  typedef enum logic {PAUSE, RUN} state_t;

  state_t             state;
  state_t             state_nx;
  logic [DIV_W-1:0]   presc;
  logic [DIV_W-1:0]   presc_nx;
  logic               tick_nx;
  logic               dir_press;
  logic               run_press;
  logic               step_press;

  updown_ctrl_btn #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_dir (
    .clk(clk), .rst(rst), .raw(btn_dir), .press(dir_press)
  );

  updown_ctrl_btn #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_run (
    .clk(clk), .rst(rst), .raw(btn_run), .press(run_press)
  );

`ifdef UPDOWN_CTRL_STEP_EN
  updown_ctrl_btn #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_step (
    .clk(clk), .rst(rst), .raw(btn_step), .press(step_press)
  );
`else
  assign step_press = 1'b0;
`endif

  // tick is registered from the next prescaler value, so it is high exactly
  // during the cycle in which the prescaler sits at DIV-1.
  always_comb begin
    state_nx = state;
    presc_nx = '0;
    tick_nx  = 1'b0;
    if (run_press) begin
      state_nx = (state == RUN) ? PAUSE : RUN;
    end
    if (state == RUN && state_nx == RUN) begin
      presc_nx = (presc == DIV_W'(DIV - 1)) ? '0 : presc + 1'b1;
    end
    if (state_nx == RUN && presc_nx == DIV_W'(DIV - 1)) begin
      tick_nx = 1'b1;
    end
    if (state == PAUSE && step_press) begin
      tick_nx = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= PAUSE;
      presc   <= '0;
      tick    <= 1'b0;
      flag    <= 1'b1;
      running <= 1'b0;
    end else begin
      state   <= state_nx;
      presc   <= presc_nx;
      tick    <= tick_nx;
      running <= (state_nx == RUN);
      if (dir_press) begin
        flag <= ~flag;
      end
    end
  end

endmodule

// File: tb/tb_updown_ctrl.sv
// Directed self-checking bench for updown_ctrl with DIV=5, DB_CYCLES=4.

module tb_updown_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic btn_dir;
  logic btn_run;
  logic tick;
  logic flag;
  logic running;
`ifdef UPDOWN_CTRL_STEP_EN
  logic btn_step = 1'b0;
`endif

  int cyc = 0;
  int start = 0;
  bit in_run = 1'b0;
  int total = 0;
  int passed = 0;
  int tick_cnt = 0;

  updown_ctrl #(.DIV(5), .DIV_W(26), .DB_CYCLES(4), .DB_W(20)) dut (
    .clk(clk),
    .rst(rst),
    .btn_dir(btn_dir),
    .btn_run(btn_run),
`ifdef UPDOWN_CTRL_STEP_EN
    .btn_step(btn_step),
`endif
    .tick(tick),
    .flag(flag),
    .running(running)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s at edge %0d: observed %b expected %b", tag, cyc, obs, exp);
  endtask

  // Advance n edges, sampling 1 time unit after each, checking tick against the
  // hand formula: in RUN the prescaler is (cyc-start)%5 and tick marks value 4.
  task automatic edges(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check("tick", tick, in_run && ((cyc - start) % 5 == 4));
      if (tick) tick_cnt++;
    end
  endtask

  int t0;

  initial begin
    rst = 1'b1;
    btn_dir = 1'b1;
    btn_run = 1'b1;

    // Reset with both buttons held
    edges(2);
    check("rst_flag", flag, 1'b1);
    check("rst_running", running, 1'b0);
    rst = 1'b0;
    btn_dir = 1'b0;
    btn_run = 1'b0;
    edges(8);
    check("idle_flag", flag, 1'b1);
    check("idle_running", running, 1'b0);

    // Run start: press qualifies 6 edges after assertion
    t0 = cyc;
    btn_run = 1'b1;
    edges(5);
    check("run_pre", running, 1'b0);
    in_run = 1'b1;
    start = t0 + 6;
    edges(1);
    check("run_on", running, 1'b1);
    edges(4);
    check("first_tick", tick, 1'b1);
    btn_run = 1'b0;
    tick_cnt = 0;
    edges(15);
    check("tick_count3", tick_cnt == 3, 1'b1);
    check("run_after_release", running, 1'b1);

    // Direction toggle while running
    t0 = cyc;
    btn_dir = 1'b1;
    edges(5);
    check("dir_pre", flag, 1'b1);
    edges(1);
    check("dir_toggle", flag, 1'b0);
    edges(2);
    btn_dir = 1'b0;
    edges(10);
    check("dir_once", flag, 1'b0);

    // Second press, exactly DB_CYCLES long: still qualifies
    btn_dir = 1'b1;
    edges(4);
    btn_dir = 1'b0;
    edges(1);
    check("dir2_pre", flag, 1'b0);
    edges(1);
    check("dir2_toggle", flag, 1'b1);
    edges(8);

    // Glitch of 3 cycles is filtered
    btn_dir = 1'b1;
    edges(3);
    btn_dir = 1'b0;
    edges(10);
    check("glitch_flag", flag, 1'b1);
    check("glitch_running", running, 1'b1);

    // Pause coincident with tick
    while ((cyc - start) % 5 != 4) edges(1);
    btn_run = 1'b1;
    edges(5);
    check("coinc_tick", tick, 1'b1);
    check("coinc_run", running, 1'b1);
    in_run = 1'b0;
    edges(1);
    check("pause_running", running, 1'b0);
    edges(4);
    btn_run = 1'b0;
    tick_cnt = 0;
    edges(15);
    check("no_ticks_paused", tick_cnt == 0, 1'b1);
    check("pause_hold", running, 1'b0);

`ifdef UPDOWN_CTRL_STEP_EN
    // Three separated step presses in PAUSE give three single ticks
    tick_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      btn_step = 1'b1;
      edges(5);
      @(posedge clk);
      #1;
      check("step_tick", tick, 1'b1);
      tick_cnt++;
      btn_step = 1'b0;
      @(posedge clk);
      #1;
      check("step_single", tick, 1'b0);
      edges(8);
    end
    check("step_count3", tick_cnt == 3, 1'b1);
`endif

    // Reset during a debounce in progress: button must re-qualify from zero
    btn_dir = 1'b1;
    edges(3);
    rst = 1'b1;
    edges(1);
    check("mid_rst_flag", flag, 1'b1);
    check("mid_rst_running", running, 1'b0);
    rst = 1'b0;
    edges(5);
    check("requal_pre", flag, 1'b1);
    edges(1);
    check("requal_toggle", flag, 1'b0);
    btn_dir = 1'b0;
    edges(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
